seg7_anode_reader: RTL and testbench
====================================

# seg7_anode_reader

Scan-side reader for multiplexed common-anode 7-segment display buses. It samples active-low segment lines and active-low digit anode strobes, and waits for each digit's dwell to settle. Each settled pattern is decoded back to a hex nibble. A full multi-digit value is assembled and presented once every digit has been captured. It sits opposite the hex-to-segment drivers and is used both as an on-board display monitor and as a loopback checker in the driver benches.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits / anode strobes
- STABLE_CYC, 8, consecutive identical post-sync samples required to accept a dwell (≥2)
- TIMEOUT, 65535, cycles without a completed frame before `stalled` asserts

Ports:
- clk  in  1  single system clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- seg_n  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}
- an_n  in  DIGITS  anode strobes, active-low; an_n[i] low selects digit i
- value  out  4*DIGITS  assembled nibbles; digit i at value[4i+3:4i]
- frame_valid  out  1  one-cycle pulse: `value` / `invalid_mask` updated
- invalid_mask  out  DIGITS  bit i set: digit i pattern was blank or not in decode table
- ghost_err  out  1  sticky: more than one anode seen low; cleared by reset only
- stalled  out  1  no frame for TIMEOUT cycles; clears on next frame_valid

## Operation
- Input conditioning: seg_n and an_n pass through a 2-flop synchronizer. Sync registers reset to all-ones (inactive). All logic below uses the synchronized copies.
- Decode table, active-low gfedcba to nibble:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7
  - 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F
- Any other pattern, including blank 0x7F, decodes to nibble 0 with the invalid bit set.
- Dwell tracker FSM:
  - WAIT: no anode or several anodes low. Stability counter held at 0. Any multi-low anode sample sets ghost_err. Exactly one anode low → SETTLE with counter=1.
  - SETTLE: each cycle {an,seg} equals the previous sample, counter increments. When counter reaches STABLE_CYC, capture and go to HELD. Any change → counter=1 and stay in SETTLE (if still exactly one anode low), else go to WAIT.
  - HELD: dwell already captured; no re-capture. Any change in {an,seg} → SETTLE or WAIT, by the same rule as SETTLE.
- Capture writes the decoded nibble and invalid bit into the staging slot for the selected digit and sets that digit's bit in capture_mask. Re-capture of a digit before frame completion overwrites its slot (latest wins).
- Frame completion: when capture_mask becomes all-ones, staging is copied to value/invalid_mask, frame_valid pulses, and capture_mask clears.
- Timeout counter: counts cycles since reset or the last frame_valid, saturating at TIMEOUT. At TIMEOUT, stalled=1. The capture mask is not cleared on stall.

## Timing
- Reset values: value=0, frame_valid=0, invalid_mask=0, ghost_err=0, stalled=0, FSM=WAIT, capture_mask=0, all counters 0. Reset mid-frame discards partial captures.
- Capture latency: if a new pattern is present at the pins from edge t onward, it is captured at edge t+2+STABLE_CYC−1 (2-cycle sync plus STABLE_CYC samples).
- frame_valid is high for exactly the cycle after the edge at which the final digit capture occurs. value is stable from that cycle until the next frame_valid.
- Completing capture and timeout reached in the same cycle: the frame wins. frame_valid pulses, the timeout counter clears, and stalled stays/goes 0.
- A dwell shorter than STABLE_CYC samples is never captured. Glitches restart the count.
- The timeout counter saturates and does not wrap. The stability counter saturates at STABLE_CYC in HELD.

## Test plan
- Drive digits 3..0 with 0x12, 0x40, 0x08, 0x79 (20-cycle dwells, 4-cycle blank gaps between them) → one frame_valid, value=0x50A1, invalid_mask=0.
- Digit 2 driven with 0x7F and digit 0 with 0x55, others valid → value nibbles 0 at digits 2 and 0, invalid_mask=4'b0101.
- Digit 1 dwell of STABLE_CYC−1 cycles only, then a valid 10-cycle dwell of 0x30 → only the second capture counts; value[7:4]=3.
- Two anodes low for 3 cycles mid-scan → ghost_err=1 and stays 1; no capture during that window; the frame still completes afterwards.
- Idle inputs (all ones) with TIMEOUT=100 → stalled=1 at cycle 100 after reset. Then a full scan → frame_valid and stalled=0 in the same cycle.
- Assert rst_n low after 3 of 4 digits are captured, then release and scan digit 0 only → no frame_valid; all outputs remain at reset values.

Source files
------------

// File: rtl/seg7_anode_reader.sv
// seg7_anode_reader: samples a multiplexed common-anode 7-segment bus.
// A digit's pattern is captured once it has been stable for STABLE_CYC samples.
// Each pattern is decoded back to a hex nibble. A complete multi-digit value is
// presented once every digit has been captured.
module seg7_anode_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     invalid_mask,
  output logic                  ghost_err,
  output logic                  stalled
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  // Active-low gfedcba pattern to {invalid, nibble}; unknown patterns read as 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [6:0]          seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0]   an_s1, an_s2, an_prev;
  logic [DIGITS-1:0]   an_low;
  logic                one_low, multi_low, same;
  state_t              state;
  logic [CW-1:0]       stab_cnt;
  logic                capture_now;
  logic [4:0]          dec;
  logic [DIGITS-1:0]   cap_hit;
  logic [DIGITS-1:0]   capture_mask, mask_next;
  logic [4*DIGITS-1:0] stage_val, stage_val_next;
  logic [DIGITS-1:0]   stage_inv, stage_inv_next;
  logic                frame_done;
  logic [TW-1:0]       tcnt;

  // Two-flop synchronizer plus a copy of the previous synchronized sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
    end else begin
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      an_s1    <= an_n;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
    end
  end

  assign an_low    = ~an_s2;
  assign multi_low = (an_low & (an_low - 1'b1)) != '0;
  assign one_low   = (an_low != '0) && !multi_low;
  assign same      = {an_s2, seg_s2} == {an_prev, seg_prev};
  assign dec       = decode(seg_s2);

  // The dwell is accepted on the sample that brings the stability count to STABLE_CYC.
  assign capture_now = (state == SETTLE) && same && one_low &&
                       (stab_cnt == CW'(STABLE_CYC - 1));
  assign cap_hit     = capture_now ? an_low : '0;
  assign mask_next   = capture_mask | cap_hit;
  assign frame_done  = capture_now && (&mask_next);

  // Staging including this cycle's capture, so the final digit lands in value.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_stage
      assign stage_val_next[4*gi +: 4] = cap_hit[gi] ? dec[3:0] : stage_val[4*gi +: 4];
      assign stage_inv_next[gi]        = cap_hit[gi] ? dec[4]   : stage_inv[gi];
    end
  endgenerate

  // Dwell tracker: wait for a single anode, count stable samples, hold after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT;
      stab_cnt  <= '0;
      ghost_err <= 1'b0;
    end else begin
      if (multi_low) ghost_err <= 1'b1;
      case (state)
        WAIT: begin
          if (one_low) begin
            state    <= SETTLE;
            stab_cnt <= CW'(1);
          end else begin
            stab_cnt <= '0;
          end
        end
        default: begin
          if (!same) begin
            state    <= one_low ? SETTLE : WAIT;
            stab_cnt <= one_low ? CW'(1) : '0;
          end else if (state == SETTLE) begin
            stab_cnt <= stab_cnt + 1'b1;
            if (capture_now) state <= HELD;
          end
        end
      endcase
    end
  end

  // Staging slots, capture mask and frame presentation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_val    <= '0;
      stage_inv    <= '0;
      capture_mask <= '0;
      value        <= '0;
      invalid_mask <= '0;
      frame_valid  <= 1'b0;
    end else begin
      stage_val   <= stage_val_next;
      stage_inv   <= stage_inv_next;
      frame_valid <= frame_done;
      if (frame_done) begin
        value        <= stage_val_next;
        invalid_mask <= stage_inv_next;
        capture_mask <= '0;
      end else begin
        capture_mask <= mask_next;
      end
    end
  end

  // Saturating frame timeout; a completed frame always wins over the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      stalled <= 1'b0;
    end else if (frame_done) begin
      tcnt    <= '0;
      stalled <= 1'b0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TW'(TIMEOUT - 1)) stalled <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_anode_reader.sv
// Scoreboard bench for seg7_anode_reader: expected frames are queued by the
// stimulus and popped by a monitor whenever frame_valid is seen.
module tb_seg7_anode_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 8;
  localparam int TMO    = 100;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] value;
  logic                frame_valid;
  logic [DIGITS-1:0]   invalid_mask;
  logic                ghost_err;
  logic                stalled;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  m;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad   = 0;

  seg7_anode_reader #(.DIGITS(DIGITS), .STABLE_CYC(STABLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .value(value),
    .frame_valid(frame_valid), .invalid_mask(invalid_mask),
    .ghost_err(ghost_err), .stalled(stalled)
  );

  always #5 clk = ~clk;

  // Monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame value=%h mask=%b", value, invalid_mask);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (value !== e.v || invalid_mask !== e.m || stalled !== 1'b0) begin
          bad++;
          $display("FAIL frame got value=%h mask=%b stalled=%b want value=%h mask=%b stalled=0",
                   value, invalid_mask, stalled, e.v, e.m);
        end else begin
          $display("frame value=%h mask=%b ok", value, invalid_mask);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic [3:0] m);
    frame_t f;
    f.v = v;
    f.m = m;
    exp_q.push_back(f);
  endtask

  // Called at a negedge: hold one digit for n cycles, then a 4-cycle blank gap.
  task automatic dwell(input int d, input logic [6:0] s, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (n) @(negedge clk);
    an_n  = '1;
    seg_n = 7'h7F;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_value", value, 16'h0000);
    check("rst_frame_valid", {15'd0, frame_valid}, 16'h0000);
    check("rst_invalid_mask", {12'd0, invalid_mask}, 16'h0000);
    check("rst_ghost_err", {15'd0, ghost_err}, 16'h0000);
    check("rst_stalled", {15'd0, stalled}, 16'h0000);

    // Idle after reset: stall appears exactly at the 100th edge.
    rst_n = 1'b1;
    repeat (99) @(posedge clk);
    #1 check("stalled_edge99", {15'd0, stalled}, 16'h0000);
    @(posedge clk);
    #1 check("stalled_edge100", {15'd0, stalled}, 16'h0001);
    @(negedge clk);

    // Basic scan; the frame also clears the stall (checked by the monitor).
    dwell(3, 7'h12, 20);
    dwell(2, 7'h40, 20);
    dwell(1, 7'h08, 20);
    expect_frame(16'h50A1, 4'b0000);
    dwell(0, 7'h79, 20);

    // Blank and out-of-table patterns.
    dwell(3, 7'h24, 20);
    dwell(2, 7'h7F, 20);
    dwell(1, 7'h19, 20);
    expect_frame(16'h2040, 4'b0101);
    dwell(0, 7'h55, 20);

    // Too-short dwell on the last missing digit must not complete a frame.
    dwell(3, 7'h02, 20);
    dwell(2, 7'h78, 20);
    dwell(0, 7'h46, 20);
    dwell(1, 7'h79, STABLE - 1);
    expect_frame(16'h673C, 4'b0000);
    dwell(1, 7'h30, 10);

    // Two anodes low mid-scan.
    check("ghost_before", {15'd0, ghost_err}, 16'h0000);
    dwell(3, 7'h00, 20);
    an_n  = 4'b1010;
    seg_n = 7'h10;
    repeat (3) @(negedge clk);
    an_n  = '1;
    seg_n = 7'h7F;
    repeat (4) @(negedge clk);
    check("ghost_set", {15'd0, ghost_err}, 16'h0001);
    dwell(2, 7'h10, 20);
    dwell(1, 7'h21, 20);
    expect_frame(16'h89DE, 4'b0000);
    dwell(0, 7'h06, 20);
    check("ghost_sticky", {15'd0, ghost_err}, 16'h0001);
    check("pending_after_scans", 16'(exp_q.size()), 16'h0000);

    // Reset mid-frame discards the three captured digits.
    dwell(3, 7'h03, 20);
    dwell(2, 7'h0E, 20);
    dwell(1, 7'h40, 20);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dwell(0, 7'h79, 20);
    repeat (20) @(negedge clk);
    check("post_rst_value", value, 16'h0000);
    check("post_rst_invalid_mask", {12'd0, invalid_mask}, 16'h0000);
    check("post_rst_ghost_err", {15'd0, ghost_err}, 16'h0000);
    check("post_rst_stalled", {15'd0, stalled}, 16'h0000);
    check("post_rst_frame_valid", {15'd0, frame_valid}, 16'h0000);
    check("pending_final", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
